// File: rtl/banco_registros_param_pkg.sv
// Shared defaults and clear-sequencer state encoding for the parametrised register bank.
package banco_registros_param_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned N_READ_DEF = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } banco_state_e;

endpackage : banco_registros_param_pkg

// File: rtl/banco_registros_param_clear_fsm.sv
// Clear sequencer: sweeps every register to zero after reset or on init_req.
module banco_clear_fsm
  import banco_registros_param_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  banco_state_e      state;
  logic [ADDR_W-1:0] idx;

  // State and sweep index; the last address hands over to READY on the same edge it is cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      idx   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          idx <= idx + ADDR_W'(1);
          if (idx == '1) begin
            state <= READY;
          end
        end
        READY: begin
          if (init_req) begin
            state <= CLEAR;
            idx   <= '0;
          end
        end
        default: begin
          state <= CLEAR;
          idx   <= '0;
        end
      endcase
    end
  end

  assign busy     = (state == CLEAR);
  assign clr_we   = (state == CLEAR);
  assign clr_addr = idx;

endmodule : banco_clear_fsm

// File: rtl/banco_registros_param.sv
// Parametrised register bank: N_READ combinational reads, one write port, hardware clear
// sweep and a pending-write scoreboard for load-use hazard detection.
module banco_registros_param
  import banco_registros_param_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned N_READ   = N_READ_DEF,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     init_req,
  output logic                     busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [N_READ*ADDR_W-1:0] ra,
  output logic [N_READ*DATA_W-1:0] rdata,
  input  logic                     pend_set,
  input  logic [ADDR_W-1:0]        pend_addr,
  output logic [N_READ-1:0]        pend
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend_bits;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic ready_c;
  logic init_go_c;
  logic wr_ok_c;
  logic pset_ok_c;

  banco_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_req (init_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // init_req outranks any write or pend_set issued in the same cycle.
  assign ready_c   = ~busy;
  assign init_go_c = ready_c & init_req;
  assign wr_ok_c   = ready_c & ~init_req & we
                   & ~((ZERO_REG != 0) && (wa == '0));
  assign pset_ok_c = ready_c & ~init_req & pend_set
                   & ~((ZERO_REG != 0) && (pend_addr == '0));

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok_c) begin
      mem[wa] <= data_in;
    end
  end

  // Scoreboard: a write retires its address, a same-cycle pend_set re-arms it (new producer).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_bits <= '0;
    end else if (busy || init_go_c) begin
      pend_bits <= '0;
    end else begin
      if (wr_ok_c) begin
        pend_bits[wa] <= 1'b0;
      end
      if (pset_ok_c) begin
        pend_bits[pend_addr] <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N_READ; i++) begin : g_rd
    logic [ADDR_W-1:0] ra_i;
    logic              hit_c;
    logic              zero_c;

    assign ra_i   = ra[i*ADDR_W +: ADDR_W];
    assign hit_c  = (BYPASS != 0) && wr_ok_c && (wa == ra_i);
    assign zero_c = (ZERO_REG != 0) && (ra_i == '0);

    assign rdata[i*DATA_W +: DATA_W] = busy   ? '0 :
                                       zero_c ? '0 :
                                       hit_c  ? data_in :
                                                mem[ra_i];

    // A forwarded value is no longer a hazard for this reader.
    assign pend[i] = ready_c & ~hit_c & pend_bits[ra_i];
  end

endmodule : banco_registros_param

// File: tb/tb_banco_registros_param.sv
// Directed bench for banco_registros_param: a BYPASS=1 and a BYPASS=0 instance share stimulus.
module tb_banco_registros_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_req;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] data_in;
  logic [4:0]  ra0;
  logic [4:0]  ra1;
  logic [9:0]  ra;
  logic        pend_set;
  logic [4:0]  pend_addr;

  logic        busy_a, busy_b;
  logic [63:0] rdata_a, rdata_b;
  logic [1:0]  pend_a, pend_b;

  int checks = 0;
  int errors = 0;

  assign ra = {ra1, ra0};

  always #5 clk = ~clk;

  banco_registros_param #(
    .DATA_W(32), .ADDR_W(5), .N_READ(2), .ZERO_REG(1), .BYPASS(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy_a),
    .we(we), .wa(wa), .data_in(data_in), .ra(ra), .rdata(rdata_a),
    .pend_set(pend_set), .pend_addr(pend_addr), .pend(pend_a)
  );

  banco_registros_param #(
    .DATA_W(32), .ADDR_W(5), .N_READ(2), .ZERO_REG(1), .BYPASS(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy_b),
    .we(we), .wa(wa), .data_in(data_in), .ra(ra), .rdata(rdata_b),
    .pend_set(pend_set), .pend_addr(pend_addr), .pend(pend_b)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] d;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        ps;
    logic [4:0]  pa;
    logic [31:0] ea0;
    logic [31:0] ea1;
    logic [1:0]  epa;
    logic [31:0] eb0;
    logic [31:0] eb1;
    logic [1:0]  epb;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle();
    init_req  = 1'b0;
    we        = 1'b0;
    wa        = 5'd0;
    data_in   = 32'd0;
    pend_set  = 1'b0;
    pend_addr = 5'd0;
  endtask

  // Counts edges while busy is high on dut_a; expects the full 32-register sweep.
  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(n), 32'd32);
    chk({name, " busy_b"}, 32'(busy_b), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      ra0 = 5'(i);
      ra1 = 5'(31 - i);
      #1;
      chk($sformatf("%s r%0d a", name, i), rdata_a[31:0] | rdata_a[63:32], 32'd0);
      chk($sformatf("%s r%0d b", name, i), rdata_b[31:0] | rdata_b[63:32], 32'd0);
      chk($sformatf("%s pend r%0d", name, i), 32'({pend_a, pend_b}), 32'd0);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd3, 5'd5, 1'b0, 5'd0,
                 32'd0, 32'hDEADBEEF, 2'b00, 32'd0, 32'd0, 2'b00};
    vecs[1]  = '{1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b0, 5'd0,
                 32'hDEADBEEF, 32'd0, 2'b00, 32'hDEADBEEF, 32'd0, 2'b00};
    vecs[2]  = '{1'b1, 5'd0, 32'h1234, 5'd0, 5'd5, 1'b1, 5'd0,
                 32'd0, 32'hDEADBEEF, 2'b00, 32'd0, 32'hDEADBEEF, 2'b00};
    vecs[3]  = '{1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0,
                 32'd0, 32'd0, 2'b00, 32'd0, 32'd0, 2'b00};
    vecs[4]  = '{1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 1'b1, 5'd7,
                 32'd0, 32'd0, 2'b00, 32'd0, 32'd0, 2'b00};
    vecs[5]  = '{1'b0, 5'd0, 32'd0, 5'd7, 5'd3, 1'b0, 5'd0,
                 32'd0, 32'd0, 2'b01, 32'd0, 32'd0, 2'b01};
    vecs[6]  = '{1'b1, 5'd7, 32'hA5A50007, 5'd7, 5'd7, 1'b0, 5'd0,
                 32'hA5A50007, 32'hA5A50007, 2'b00, 32'd0, 32'd0, 2'b11};
    vecs[7]  = '{1'b0, 5'd0, 32'd0, 5'd7, 5'd5, 1'b0, 5'd0,
                 32'hA5A50007, 32'hDEADBEEF, 2'b00, 32'hA5A50007, 32'hDEADBEEF, 2'b00};
    vecs[8]  = '{1'b1, 5'd7, 32'h77, 5'd7, 5'd4, 1'b1, 5'd7,
                 32'h77, 32'd0, 2'b00, 32'hA5A50007, 32'd0, 2'b00};
    vecs[9]  = '{1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 1'b0, 5'd0,
                 32'h77, 32'h77, 2'b11, 32'h77, 32'h77, 2'b11};
    vecs[10] = '{1'b1, 5'd5, 32'h5555, 5'd5, 5'd7, 1'b1, 5'd9,
                 32'h5555, 32'h77, 2'b10, 32'hDEADBEEF, 32'h77, 2'b10};
    vecs[11] = '{1'b0, 5'd0, 32'd0, 5'd9, 5'd5, 1'b0, 5'd0,
                 32'd0, 32'h5555, 2'b01, 32'd0, 32'h5555, 2'b01};
    vecs[12] = '{1'b1, 5'd9, 32'd9, 5'd9, 5'd9, 1'b1, 5'd5,
                 32'd9, 32'd9, 2'b00, 32'd0, 32'd0, 2'b11};
    vecs[13] = '{1'b0, 5'd0, 32'd0, 5'd5, 5'd9, 1'b0, 5'd0,
                 32'h5555, 32'd9, 2'b01, 32'h5555, 32'd9, 2'b01};

    rst_n = 1'b0;
    ra0   = 5'd0;
    ra1   = 5'd0;
    idle();

    // Reset for two cycles, then the power-up sweep.
    repeat (2) @(negedge clk);
    #1;
    chk("busy in reset", 32'({busy_a, busy_b}), 32'h3);
    chk("rdata in reset", rdata_a[31:0] | rdata_a[63:32], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    we    = 1'b1;
    wa    = 5'd4;
    data_in = 32'hBAD0;
    pend_set = 1'b1;
    pend_addr = 5'd4;
    ra0 = 5'd4;
    count_busy("reset sweep");
    idle();
    check_all_zero("post reset");

    // Directed vector table.
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      we        = vecs[k].we;
      wa        = vecs[k].wa;
      data_in   = vecs[k].d;
      ra0       = vecs[k].ra0;
      ra1       = vecs[k].ra1;
      pend_set  = vecs[k].ps;
      pend_addr = vecs[k].pa;
      #1;
      chk($sformatf("vec%0d rdata0_a", k), rdata_a[31:0],  vecs[k].ea0);
      chk($sformatf("vec%0d rdata1_a", k), rdata_a[63:32], vecs[k].ea1);
      chk($sformatf("vec%0d pend_a", k),   32'(pend_a),    32'(vecs[k].epa));
      chk($sformatf("vec%0d rdata0_b", k), rdata_b[31:0],  vecs[k].eb0);
      chk($sformatf("vec%0d rdata1_b", k), rdata_b[63:32], vecs[k].eb1);
      chk($sformatf("vec%0d pend_b", k),   32'(pend_b),    32'(vecs[k].epb));
    end

    // Fill r1..r31 with their index and arm a pending bit.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      idle();
      we      = 1'b1;
      wa      = 5'(i);
      data_in = 32'(i);
    end
    @(negedge clk);
    idle();
    pend_set  = 1'b1;
    pend_addr = 5'd10;
    @(negedge clk);
    idle();
    ra0 = 5'd31;
    ra1 = 5'd10;
    #1;
    chk("fill r31", rdata_a[31:0], 32'd31);
    chk("fill r10", rdata_b[63:32], 32'd10);
    chk("pend r10 armed", 32'(pend_a), 32'h2);

    // init_req with a competing write and pend_set: both discarded.
    @(negedge clk);
    init_req  = 1'b1;
    we        = 1'b1;
    wa        = 5'd3;
    data_in   = 32'hFFFF;
    pend_set  = 1'b1;
    pend_addr = 5'd3;
    ra0 = 5'd3;
    ra1 = 5'd10;
    #1;
    chk("init cycle no bypass", rdata_a[31:0], 32'd3);
    chk("init cycle busy", 32'(busy_a), 32'd0);
    @(posedge clk);
    #1;
    chk("init accepted busy", 32'({busy_a, busy_b}), 32'h3);
    @(negedge clk);
    idle();
    we      = 1'b1;
    wa      = 5'd31;
    data_in = 32'hBAD;
    pend_set  = 1'b1;
    pend_addr = 5'd31;
    ra0 = 5'd31;
    ra1 = 5'd10;
    #1;
    chk("sweep rdata", rdata_a[31:0] | rdata_a[63:32], 32'd0);
    chk("sweep pend", 32'({pend_a, pend_b}), 32'd0);
    count_busy("init sweep");
    idle();
    check_all_zero("post init");

    // Reset in the middle of a sweep restarts the full 32-cycle clear.
    @(negedge clk);
    init_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init_req = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid-sweep busy", 32'(busy_a), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    count_busy("restart sweep");

    @(negedge clk);
    we      = 1'b1;
    wa      = 5'd6;
    data_in = 32'h66;
    @(negedge clk);
    idle();
    ra0 = 5'd6;
    ra1 = 5'd2;
    #1;
    chk("after restart r6", rdata_b[31:0], 32'h66);
    chk("after restart r2", rdata_a[63:32], 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_banco_registros_param
